truth_table_sweeper: RTL

- Self-contained exhaustive stimulus and response-capture stage for small combinational blocks under lab test, such as the 5-input single-output functions.
- Drives every input combination in ascending binary order, with bit N_IN-1 as the MSB input (a).
- Waits a settle interval, samples the DUT output and builds the full truth table.
- Compares the table against an expected table latched at start, reporting pass/fail, mismatch count and first failing index.

---
 rtl/truth_table_sweeper_if.sv | 26 ++
 rtl/truth_table_sweeper.sv | 98 +++++++++
 2 files changed

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response bundle between the truth-table sweeper and its controller.
// The controller (master) starts sweeps and supplies f_in; the sweeper (slave) drives vectors and results.
interface truth_table_sweeper_if #(
    parameter int N_IN = 5
);
    logic                  start;
    logic [2**N_IN-1:0]    expected;
    logic                  f_in;
    logic [N_IN-1:0]       vec;
    logic                  busy;
    logic                  done;
    logic [2**N_IN-1:0]    tt;
    logic                  pass;
    logic [N_IN:0]         mismatch_cnt;
    logic [N_IN-1:0]       first_fail;

    modport master (
        output start, expected, f_in,
        input  vec, busy, done, tt, pass, mismatch_cnt, first_fail
    );

    modport slave (
        input  start, expected, f_in,
        output vec, busy, done, tt, pass, mismatch_cnt, first_fail
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector in ascending order, holds it SETTLE
// cycles, samples f_in, and compares the captured table against an expected table latched at start.
module truth_table_sweeper #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int                DEPTH     = 2**N_IN;
    localparam logic [N_IN-1:0]   VEC_LAST  = '1;
    localparam logic [3:0]        HOLD_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t             state;
    logic [3:0]         hold;
    logic [DEPTH-1:0]   exp_q;
    logic [N_IN-1:0]    vec_q;
    logic               busy_q;
    logic               done_q;
    logic [DEPTH-1:0]   tt_q;
    logic               pass_q;
    logic [N_IN:0]      mismatch_q;
    logic [N_IN-1:0]    first_fail_q;

    logic               bit_miss;
    assign bit_miss = (bus.f_in != exp_q[vec_q]);

    // NOTE: all state below is updated with <= so every branch reads pre-edge values;
    // the table registers are plain flops and take part in reset like any other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold         <= '0;
            exp_q        <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tt_q         <= '0;
            pass_q       <= 1'b0;
            mismatch_q   <= '0;
            first_fail_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        exp_q        <= bus.expected;
                        tt_q         <= '0;
                        mismatch_q   <= '0;
                        first_fail_q <= '0;
                        vec_q        <= '0;
                        hold         <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        state        <= DRIVE;
                    end
                end

                DRIVE: begin
                    hold <= hold + 4'd1;
                    if (hold == HOLD_LAST) state <= SAMPLE;
                end

                SAMPLE: begin
                    tt_q[vec_q] <= bus.f_in;
                    if (bit_miss) begin
                        mismatch_q <= mismatch_q + (N_IN+1)'(1);
                        if (mismatch_q == '0) first_fail_q <= vec_q;
                    end
                    if (vec_q == VEC_LAST) begin
                        // pass must include this last sample, so it is formed from next-count terms.
                        pass_q <= (mismatch_q == '0) && !bit_miss;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        vec_q <= vec_q + N_IN'(1);
                        hold  <= '0;
                        state <= DRIVE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vec          = vec_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.tt           = tt_q;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = mismatch_q;
    assign bus.first_fail   = first_fail_q;
endmodule
